// File: rtl/div_pkg.sv
// Shared definitions for the iterative-divide sequencer: widths, op encodings,
// per-slot metadata and the radix-2 step used by every divider stage.
package div_pkg;

    localparam int XLEN        = 32;
    localparam int DIV_LATENCY = 8;
    localparam int TAG_W       = 5;
    localparam int STEP_BITS   = XLEN / DIV_LATENCY;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef struct packed {
        logic             valid;
        div_op_e          op;
        logic [TAG_W-1:0] tag;
        logic             neg_q;
        logic             neg_r;
        logic             b_zero;
    } div_meta_t;

    typedef struct packed {
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
    } div_step_t;

    // STEP_BITS iterations of restoring division; quo shifts dividend bits out
    // from the top and quotient bits in at the bottom.
    function automatic div_step_t div_step(input logic [XLEN-1:0] rem,
                                           input logic [XLEN-1:0] quo,
                                           input logic [XLEN-1:0] dvs);
        div_step_t s;
        logic [XLEN:0] trial;
        s.rem = rem;
        s.quo = quo;
        for (int i = 0; i < STEP_BITS; i++) begin
            trial = {s.rem, s.quo[XLEN-1]};
            if (trial >= {1'b0, dvs}) begin
                trial = trial - {1'b0, dvs};
                s.quo = {s.quo[XLEN-2:0], 1'b1};
            end else begin
                s.quo = {s.quo[XLEN-2:0], 1'b0};
            end
            s.rem = trial[XLEN-1:0];
        end
        return s;
    endfunction

endpackage

// File: rtl/DividerUnsignedPipelined.sv
// Fixed-latency unsigned divider: DIV_LATENCY register stages, each resolving
// STEP_BITS quotient bits. The whole pipe freezes while stall_i is high.
module DividerUnsignedPipelined
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN-1:0] rem_q [DIV_LATENCY];
    logic [XLEN-1:0] quo_q [DIV_LATENCY];
    logic [XLEN-1:0] dvs_q [DIV_LATENCY-1];
    div_step_t       step  [DIV_LATENCY];

    always_comb begin
        step[0] = div_step('0, dividend_i, divisor_i);
        for (int k = 1; k < DIV_LATENCY; k++) begin
            step[k] = div_step(rem_q[k-1], quo_q[k-1], dvs_q[k-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DIV_LATENCY; k++) begin
                rem_q[k] <= '0;
                quo_q[k] <= '0;
            end
            for (int k = 0; k < DIV_LATENCY - 1; k++) begin
                dvs_q[k] <= '0;
            end
        end else if (!stall_i) begin
            for (int k = 0; k < DIV_LATENCY; k++) begin
                rem_q[k] <= step[k].rem;
                quo_q[k] <= step[k].quo;
            end
            dvs_q[0] <= divisor_i;
            for (int k = 1; k < DIV_LATENCY - 1; k++) begin
                dvs_q[k] <= dvs_q[k-1];
            end
        end
    end

    assign quotient_o  = quo_q[DIV_LATENCY-1];
    assign remainder_o = rem_q[DIV_LATENCY-1];

endmodule

// File: rtl/div_sequencer.sv
// RISC-V DIV/DIVU/REM/REMU front end: sign-strips operands into the unsigned
// divider and carries per-slot metadata to re-apply signs at the output.
module div_sequencer
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a stalled response holds all fields.
    logic            stall;
    logic            accept;
    logic            rsp_fire;
    logic            is_signed;
    logic            rsp_is_rem;
    logic            rsp_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN-1:0] quo, rem, res;
    div_meta_t       meta_in;
    div_meta_t       last;
    div_meta_t       meta_q [DIV_LATENCY];
    logic [3:0]      cnt_q, cnt_d;

    assign last      = meta_q[DIV_LATENCY-1];
    assign rsp_valid = last.valid && !flush;
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall && !flush;
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign is_signed = !req_op[0];
    assign a_abs     = (is_signed && req_a[XLEN-1]) ? -req_a : req_a;
    assign b_abs     = (is_signed && req_b[XLEN-1]) ? -req_b : req_b;

    always_comb begin
        meta_in.valid  = accept;
        meta_in.op     = div_op_e'(req_op);
        meta_in.tag    = req_tag;
        meta_in.neg_q  = is_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]) && (req_b != '0);
        meta_in.neg_r  = is_signed && req_a[XLEN-1];
        meta_in.b_zero = (req_b == '0);
    end

    DividerUnsignedPipelined u_divider (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall),
        .dividend_i  (a_abs),
        .divisor_i   (b_abs),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIV_LATENCY; i++) meta_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DIV_LATENCY; i++) meta_q[i].valid <= 1'b0;
        end else if (!stall) begin
            meta_q[0] <= meta_in;
            for (int i = 1; i < DIV_LATENCY; i++) meta_q[i] <= meta_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, rsp_fire})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

    // Divide-by-zero keeps the divider's all-ones quotient unnegated.
    always_comb begin
        rsp_is_rem = (last.op == OP_REM) || (last.op == OP_REMU);
        res        = rsp_is_rem ? rem : quo;
        rsp_neg    = rsp_is_rem ? last.neg_r : (last.neg_q && !last.b_zero);
        rsp_data   = '0;
        if (last.valid) rsp_data = rsp_neg ? -res : res;
    end

    assign rsp_tag = last.tag;
    assign busy    = (cnt_q != 4'd0);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized bench for div_sequencer with a tag/data scoreboard
// checked on every response handshake.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    bit          rand_rdy = 1'b0;
    logic [36:0] exp_q[$];

    div_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp);
        int n = 0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 60) begin
            tick;
            n++;
        end
        chk("req_accept", req_ready, 1);
        if (req_ready) exp_q.push_back({tag, exp});
        tick;
        req_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [4:0] tag);
        logic [1:0]  op;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
        endcase
        send(op, a, b, tag, model(op, a, b));
    endtask

    task automatic wait_rsp(output int k);
        k = 1;
        while (!rsp_valid && k < 30) begin
            tick;
            k++;
        end
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_rsp got tag=%0h data=%0h exp=none", rsp_tag, rsp_data);
            end
            if (exp_q.size() != 0) chk("rsp_tag_data", {27'd0, rsp_tag, rsp_data}, {27'd0, exp_q.pop_front()});
        end
    end

    initial begin
        int  k;
        bit  seen;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
        tick;
        tick;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        rst = 1'b0;
        tick;
        chk("ready_after_rst", req_ready, 1);

        // Unsigned basics and fixed latency
        send(2'b01, 32'd100, 32'd7, 5'd1, 32'd14);
        wait_rsp(k);
        chk("lat_divu", k, 8);
        drain;
        send(2'b11, 32'd100, 32'd7, 5'd2, 32'd2);
        drain;

        // Signed cases, divide by zero and overflow, back to back
        send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD);
        send(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF);
        send(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1);
        send(2'b00, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF);
        send(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd7, 32'hFFFF_FFFB);
        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0);
        drain;
        chk("busy_after_signed", busy, 0);

        // Eight back-to-back then consumer stall for cycles 8-10
        for (int t = 0; t < 8; t++) send_rand(5'(t));
        rsp_ready = 1'b0;
        #1;
        chk("stall_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_ready", req_ready, 0);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_tag", rsp_tag, 0);
            chk("stall_rsp_data", rsp_data, exp_q[0][31:0]);
            tick;
        end
        rsp_ready = 1'b1;
        drain;
        chk("busy_after_b2b", busy, 0);

        // Flush with three in flight; op with flush must not be taken
        tick;
        send_rand(5'd10);
        send_rand(5'd11);
        send_rand(5'd12);
        flush = 1'b1;
        req_valid = 1'b1;
        req_tag = 5'd31;
        #1;
        chk("flush_req_ready", req_ready, 0);
        chk("flush_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        tick;
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_rsp_valid_next", rsp_valid, 0);
        send(2'b01, 32'd1000, 32'd10, 5'd20, 32'd100);
        wait_rsp(k);
        chk("lat_after_flush", k, 8);
        drain;

        // Reset mid-operation loses the op
        send(2'b11, 32'd12345, 32'd77, 5'd21, 32'd12345 % 32'd77);
        tick;
        tick;
        rst = 1'b1;
        exp_q.delete();
        tick;
        rst = 1'b0;
        chk("busy_after_mid_rst", busy, 0);
        seen = 1'b0;
        for (int c = 4; c <= 12; c++) begin
            if (rsp_valid) seen = 1'b1;
            tick;
        end
        chk("no_rsp_after_rst", seen, 0);

        // Random traffic with a randomly stalling consumer
        rand_rdy = 1'b1;
        for (int t = 0; t < 24; t++) send_rand(5'(t));
        drain;
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        tick;
        chk("busy_after_random", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port flush, input, 1 bit: squash every in-flight operation.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-006 SHALL have port req_op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-007 SHALL have port req_a, input, 32 bits: dividend (rs1).
REQ-008 SHALL have port req_b, input, 32 bits: divisor (rs2).
REQ-009 SHALL have port req_tag, input, 5 bits: destination tag, returned unchanged.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port rsp_data, output, 32 bits: quotient or remainder per op.
REQ-013 SHALL have port rsp_tag, output, 5 bits: tag of the result.
REQ-014 SHALL have port busy, output, 1 bit: in-flight count is non-zero.

Function
REQ-015 SHALL accept a request on a clock edge where req_valid && req_ready.
REQ-016 SHALL drive req_ready = !stall && !flush, where stall = rsp_valid && !rsp_ready.
REQ-017 SHALL feed the internal 8-stage unsigned divider with |req_a| and |req_b| for DIV/REM, and raw operands for DIVU/REMU.
REQ-018 SHALL assert the divider stall input exactly when stall = 1; divider stages and metadata then hold.
REQ-019 SHALL carry an 8-entry metadata shift register {valid, op, tag, neg_q, neg_r, b_zero}, advancing in lockstep with the divider.
  - valid is 0 on non-accept cycles (bubble).
REQ-020 SHALL compute metadata at accept as follows:
  - neg_q = signed && (a[31] ^ b[31]) && b != 0
  - neg_r = signed && a[31]
  - b_zero = (b == 0)
REQ-021 SHALL present a result in the 8th cycle after its accept cycle with rsp_valid = meta[7].valid (fixed latency 8, back-to-back throughput 1/cycle).
REQ-022 SHALL form rsp_data as follows:
  - DIV/DIVU: quotient, two's-complement negated if neg_q.
  - REM/REMU: remainder, negated if neg_r.
REQ-023 SHALL, for divide-by-zero, return quotient 0xFFFFFFFF and remainder equal to the original dividend (falls out of the unsigned divider plus REQ-020).
REQ-024 SHALL, for signed overflow (0x80000000 / 0xFFFFFFFF), return quotient 0x80000000 and remainder 0, with no special path.
REQ-025 SHALL hold rsp_valid, rsp_data and rsp_tag stable while stall = 1.
REQ-026 SHALL, on flush, clear all metadata valid bits at that edge and force rsp_valid = 0 in the flush cycle.
  - Flush during stall releases the stall on the next cycle.
  - A req_valid coinciding with flush is not accepted.
REQ-027 SHALL maintain a 4-bit in-flight counter:
  - +1 on accept, -1 on rsp handshake, both in the same cycle means no change.
  - Zeroed on flush or rst.
  - Never exceeds 8.

Reset
REQ-028 SHALL, on rst, clear metadata valid bits, the in-flight counter and the divider stage registers.
REQ-029 SHALL drive rsp_valid = 0, busy = 0, rsp_data = 0 and rsp_tag = 0 in the cycle after rst.
REQ-030 SHALL lose any operation in flight when rst is asserted mid-operation; no response is produced for it.
REQ-031 SHALL drive req_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL take op encodings, DIV_LATENCY = 8 and the tag width from the shared package div_pkg.
REQ-033 SHALL instantiate exactly one sub-module, DividerUnsignedPipelined; sign handling and metadata stay in div_sequencer.

Verification
REQ-034 SHALL cover: DIVU 100/7 accepted at cycle 0 -> rsp_valid at cycle 8, rsp_data 14; REMU 100/7 -> 2.
REQ-035 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
REQ-036 SHALL cover: DIV 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
REQ-037 SHALL cover: 8 back-to-back requests with tags 0..7 and rsp_ready = 0 for cycles 8-10 -> req_ready = 0 for cycles 8-10, results emitted in tag order with no loss or duplication, busy = 0 after the last.
REQ-038 SHALL cover: flush at cycle 4 with 3 ops in flight -> no rsp_valid for them, busy = 0 next cycle, a new op accepted at cycle 5 returns at cycle 13.
REQ-039 SHALL cover: rst asserted at cycle 3 mid-operation -> rsp_valid stays 0 through cycle 12.
